// File: rtl/pos_read_controller_pkg.sv
// Shared MD package: position types plus the read-controller FSM encoding and
// the default ID width used by the position-read path.
package pos_read_controller_pkg;

    localparam int DEFAULT_PARTICLE_ID_WIDTH = 7;

    typedef logic [31:0] pos_coord_t;

    typedef struct packed {
        pos_coord_t x;
        pos_coord_t y;
        pos_coord_t z;
    } position_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_NUM   = 3'd1,
        WAIT_NUM = 3'd2,
        SWEEP    = 3'd3,
        DRAIN    = 3'd4,
        FINISH   = 3'd5
    } read_state_t;

endpackage

// File: rtl/pos_read_controller.sv
// Sweeps every (reference, neighbour) particle pair of a home cell, presenting
// each pair in phase 0 and then phase 1, with back-pressure stalls and a drain tail.
module pos_read_controller
    import pos_read_controller_pkg::*;
#(
    parameter int PARTICLE_ID_WIDTH = DEFAULT_PARTICLE_ID_WIDTH,
    parameter int DRAIN_CYCLES      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         back_pressure,
    input  logic [PARTICLE_ID_WIDTH-1:0] home_particle_count,
    output logic                         phase,
    output logic                         reading_particle_num,
    output logic                         pause_reading,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         busy,
    output logic                         done
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [PARTICLE_ID_WIDTH-1:0] ONE = PARTICLE_ID_WIDTH'(1);

    read_state_t                  state, state_next;
    logic [DRAIN_W-1:0]           drain_cnt, drain_next;
    logic                         phase_next;
    logic [PARTICLE_ID_WIDTH-1:0] pid_next, ref_next;
    logic                         stall;

    // A stall is decided at the same edge that raises pause_reading, so the
    // cycle showing pause_reading=1 repeats the previous pair exactly.
    assign stall = back_pressure && (state == SWEEP);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_next = state;
        drain_next = drain_cnt;
        phase_next = phase;
        pid_next   = particle_id;
        ref_next   = ref_id;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RD_NUM;
                    phase_next = 1'b0;
                    pid_next   = '0;
                    ref_next   = '0;
                end
            end

            RD_NUM: begin
                phase_next = ~phase;
                if (phase) state_next = WAIT_NUM;
            end

            // phase doubles as the two-cycle timer here
            WAIT_NUM: begin
                phase_next = ~phase;
                if (phase) begin
                    if (home_particle_count == '0) begin
                        state_next = DRAIN;
                        drain_next = DRAIN_LAST;
                    end else begin
                        state_next = SWEEP;
                        pid_next   = ONE;
                        ref_next   = ONE;
                    end
                end
            end

            SWEEP: begin
                if (!stall) begin
                    phase_next = ~phase;
                    if (phase) begin
                        if (particle_id < home_particle_count) begin
                            pid_next = particle_id + ONE;
                        end else if (ref_id < home_particle_count) begin
                            ref_next = ref_id + ONE;
                            pid_next = ONE;
                        end else begin
                            // Out-of-range IDs tell the preprocessor the sweep is over.
                            ref_next   = home_particle_count + ONE;
                            pid_next   = home_particle_count + ONE;
                            state_next = DRAIN;
                            drain_next = DRAIN_LAST;
                        end
                    end
                end
            end

            DRAIN: begin
                if (drain_cnt == '0) state_next = FINISH;
                else                 drain_next = drain_cnt - DRAIN_W'(1);
            end

            FINISH: begin
                state_next = IDLE;
                phase_next = 1'b0;
                pid_next   = '0;
                ref_next   = '0;
            end

            default: begin
                state_next = IDLE;
                phase_next = 1'b0;
                pid_next   = '0;
                ref_next   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: reset is synchronous and active-high to match the rest of
            // this codebase; every output register is cleared, not just state.
            state                <= IDLE;
            drain_cnt            <= '0;
            phase                <= 1'b0;
            particle_id          <= '0;
            ref_id               <= '0;
            reading_particle_num <= 1'b0;
            pause_reading        <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            state                <= state_next;
            drain_cnt            <= drain_next;
            phase                <= phase_next;
            particle_id          <= pid_next;
            ref_id               <= ref_next;
            reading_particle_num <= (state_next == RD_NUM);
            pause_reading        <= stall;
            busy                 <= (state_next != IDLE);
            done                 <= (state_next == FINISH);
        end
    end

endmodule

// File: tb/tb_pos_read_controller.sv
// Self-checking bench: the expected per-cycle output trace is built from the
// sweep rules as a list of beats, replayed with a stall rule under random back-pressure.
module tb_pos_read_controller;

    localparam int W  = 7;
    localparam int DC = 4;

    localparam int K_RD     = 0;
    localparam int K_WAIT0  = 1;
    localparam int K_WAIT1  = 2;
    localparam int K_SWEEP  = 3;
    localparam int K_DRAIN  = 4;
    localparam int K_FINISH = 5;
    localparam int K_IDLE   = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         back_pressure;
    logic [W-1:0] home_particle_count;
    logic         phase;
    logic         reading_particle_num;
    logic         pause_reading;
    logic [W-1:0] particle_id;
    logic [W-1:0] ref_id;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    pos_read_controller #(
        .PARTICLE_ID_WIDTH(W),
        .DRAIN_CYCLES     (DC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .back_pressure       (back_pressure),
        .home_particle_count (home_particle_count),
        .phase               (phase),
        .reading_particle_num(reading_particle_num),
        .pause_reading       (pause_reading),
        .particle_id         (particle_id),
        .ref_id              (ref_id),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        logic [W-1:0] pid;
        logic [W-1:0] rid;
        logic         ph;
        logic         ph_care;
    } beat_t;

    beat_t beats[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] pack(input logic b, input logic d, input logic r,
                                         input logic p, input logic ph,
                                         input logic [W-1:0] rid, input logic [W-1:0] pid);
        return 32'({b, d, r, p, ph, rid, pid});
    endfunction

    function automatic beat_t mk(input int kind, input int rid, input int pid,
                                 input logic ph, input logic care);
        beat_t b;
        b.kind = kind; b.rid = W'(rid); b.pid = W'(pid); b.ph = ph; b.ph_care = care;
        return b;
    endfunction

    // Expected trace of one unstalled sweep, from start to the idle cycle after done.
    task automatic build(input int n);
        int last;
        beats.delete();
        beats.push_back(mk(K_RD, 0, 0, 1'b0, 1'b1));
        beats.push_back(mk(K_RD, 0, 0, 1'b1, 1'b1));
        beats.push_back(mk(K_WAIT0, 0, 0, 1'b0, 1'b0));
        beats.push_back(mk(K_WAIT1, 0, 0, 1'b0, 1'b0));
        for (int r = 1; r <= n; r++)
            for (int p = 1; p <= n; p++) begin
                beats.push_back(mk(K_SWEEP, r, p, 1'b0, 1'b1));
                beats.push_back(mk(K_SWEEP, r, p, 1'b1, 1'b1));
            end
        last = (n == 0) ? 0 : n + 1;
        for (int i = 0; i < DC; i++) beats.push_back(mk(K_DRAIN, last, last, 1'b0, 1'b0));
        beats.push_back(mk(K_FINISH, last, last, 1'b0, 1'b0));
        beats.push_back(mk(K_IDLE, 0, 0, 1'b0, 1'b1));
    endtask

    // mode 0: no back-pressure, 1: random, 2: three cycles at phase 1 of pair (1,2)
    task automatic run_sweep(input int n, input int mode, output int pauses);
        int    idx, stalls, cyc, done_at;
        logic  pend, bp, ph_obs;
        beat_t e;
        build(n);
        @(negedge clk);
        start = 1'b1;
        home_particle_count = W'(n);
        @(negedge clk);
        start = 1'b0;
        idx = 0; stalls = 0; cyc = 0; done_at = -1; pend = 1'b0; pauses = 0;
        while (idx < beats.size()) begin
            e = beats[idx];
            ph_obs = e.ph_care ? phase : e.ph;
            check($sformatf("n%0d m%0d beat%0d", n, mode, idx),
                  pack(busy, done, reading_particle_num, pause_reading, ph_obs, ref_id, particle_id),
                  pack(e.kind != K_IDLE, e.kind == K_FINISH, e.kind == K_RD, pend,
                       e.ph, e.rid, e.pid));
            if (pause_reading) pauses++;
            if (done && done_at < 0) done_at = cyc;

            bp = 1'b0;
            if (mode == 1 && e.kind == K_SWEEP && stalls < 200)
                bp = ($urandom_range(0, 9) < 3);
            if (mode == 2 && e.kind == K_SWEEP && e.rid == 1 && e.pid == 2 && e.ph && stalls < 3)
                bp = 1'b1;
            back_pressure = bp;
            // count must only matter at WAIT_NUM exit and in SWEEP
            if (e.kind == K_WAIT1 || e.kind == K_SWEEP)
                home_particle_count = W'(n);
            else
                home_particle_count = W'($urandom_range(0, 126));
            start = (e.kind == K_SWEEP || e.kind == K_DRAIN) && ($urandom_range(0, 3) == 0);

            if (bp && e.kind == K_SWEEP) begin
                pend = 1'b1;
                stalls++;
            end else begin
                pend = 1'b0;
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        back_pressure = 1'b0;
        start = 1'b0;
        check($sformatf("done_latency n%0d", n), 32'(done_at), 32'(4 + 2 * n * n + DC + stalls));
    endtask

    initial begin
        int pauses;
        int done_seen;
        rst = 1'b1; start = 1'b0; back_pressure = 1'b0; home_particle_count = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              pack(busy, done, reading_particle_num, pause_reading, phase, ref_id, particle_id), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs",
              pack(busy, done, reading_particle_num, pause_reading, phase, ref_id, particle_id), 32'd0);

        run_sweep(3, 0, pauses);
        check("count3_pauses", 32'(pauses), 32'd0);
        run_sweep(0, 0, pauses);
        run_sweep(2, 2, pauses);
        check("bp3_pauses", 32'(pauses), 32'd3);

        // reset during the third SWEEP cycle
        @(negedge clk);
        start = 1'b1; home_particle_count = W'(2);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_sweep3",
              pack(busy, done, reading_particle_num, pause_reading, phase, ref_id, particle_id),
              pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W'(1), W'(2)));
        rst = 1'b1;
        @(negedge clk);
        check("mid_sweep_reset",
              pack(busy, done, reading_particle_num, pause_reading, phase, ref_id, particle_id), 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 32'd0);
        run_sweep(2, 0, pauses);

        for (int i = 0; i < 6; i++) run_sweep($urandom_range(1, 6), 1, pauses);

        run_sweep(126, 0, pauses);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pos_read_controller.md
POS_READ_CONTROLLER -- requirements
Module: pos_read_controller

Interface
REQ-001 Parameter PARTICLE_ID_WIDTH, default 7, SHALL set the width of every particle/reference ID and count.
REQ-002 Parameter DRAIN_CYCLES, default 4, SHALL set the number of flush cycles after the last pair is issued.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a cell sweep; ignored outside IDLE.
REQ-006 back_pressure  input  1  downstream filter buffers almost full; request to stall.
REQ-007 home_particle_count  input  PARTICLE_ID_WIDTH  home-cell count captured by the preprocessor.
REQ-008 phase  output  1  global phase: 0 selects neighbour cells 0..6, 1 selects 7..13.
REQ-009 reading_particle_num  output  1  memory address 0 (the particle count) is being read.
REQ-010 pause_reading  output  1  issued data is stalled this cycle.
REQ-011 particle_id  output  PARTICLE_ID_WIDTH  neighbour read address, broadcast to all cells.
REQ-012 ref_id  output  PARTICLE_ID_WIDTH  reference particle index.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on sweep completion.

Function
REQ-015 The FSM SHALL use the states IDLE, RD_NUM, WAIT_NUM, SWEEP, DRAIN and FINISH; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 SHALL cause a transition to RD_NUM with particle_id=0, ref_id=0 and phase=0.
REQ-017 RD_NUM SHALL last 2 cycles (phase 0 then phase 1) with reading_particle_num=1 and particle_id=0, then go to WAIT_NUM.
REQ-018 WAIT_NUM SHALL last 2 cycles; on exit, if home_particle_count==0 the FSM SHALL go to DRAIN, otherwise to SWEEP with ref_id=1, particle_id=1, phase=0.
REQ-019 In SWEEP, each unstalled cycle SHALL toggle phase, so every particle_id is presented in phase 0 and then phase 1.
REQ-020 In SWEEP, on an unstalled phase-1 cycle with particle_id<home_particle_count, particle_id SHALL increment by 1.
REQ-021 On an unstalled phase-1 cycle with particle_id==home_particle_count and ref_id<home_particle_count, the next cycle SHALL have ref_id+1, particle_id=1 and phase=0.
REQ-022 On an unstalled phase-1 cycle with particle_id==ref_id==home_particle_count, the FSM SHALL set ref_id=home_particle_count+1 and particle_id=home_particle_count+1, then enter DRAIN. These out-of-range values make the preprocessor's reading_done and broadcast_done true.
REQ-023 pause_reading SHALL be registered as (back_pressure & state==SWEEP); in any cycle where pause_reading=1, phase, particle_id and ref_id SHALL hold.
REQ-024 A pause that begins in either phase SHALL resume in that same phase, with no pair skipped or duplicated.
REQ-025 DRAIN SHALL last exactly DRAIN_CYCLES cycles with IDs held and pause_reading=0, then go to FINISH.
REQ-026 FINISH SHALL assert done for 1 cycle, then return to IDLE with phase=0.
REQ-027 Counter arithmetic SHALL be unsigned PARTICLE_ID_WIDTH; home_particle_count SHALL be ≤ 2^PARTICLE_ID_WIDTH-2, so count+1 never wraps.
REQ-028 home_particle_count SHALL be sampled only on WAIT_NUM exit and in SWEEP; changes in other states SHALL be ignored.

Reset
REQ-029 While rst=1, the state SHALL be IDLE and every output SHALL be 0.
REQ-030 rst asserted mid-sweep SHALL abort the sweep within one cycle and SHALL NOT produce a done pulse.

Structure
REQ-031 The FSM state enum and the default PARTICLE_ID_WIDTH SHALL live in the shared MD package, alongside the existing position types.
REQ-032 The block SHALL be a single module with no sub-modules; the DRAIN counter SHALL be local to it.

Verification
REQ-033 Scenario: count=3, no back_pressure -> 9 (ref,particle) pairs, each shown phase 0 then 1, SWEEP lasting 18 cycles; final ids=4/4; done pulse exactly 2+2+18+4 cycles after RD_NUM entry.
REQ-034 Scenario: count=0 -> RD_NUM, WAIT_NUM, DRAIN(4), done; no SWEEP cycle ever occurs.
REQ-035 Scenario: count=2, back_pressure high for 3 cycles starting at the phase-1 cycle of (1,2) -> pause_reading high for 3 cycles, outputs frozen, resume at phase 1 of (1,2); total pair order unchanged.
REQ-036 Scenario: rst pulsed at the third SWEEP cycle -> next cycle state IDLE, all outputs 0, no done; a following start runs a full clean sweep.
REQ-037 Scenario: start asserted during SWEEP and during DRAIN -> ignored, no restart.
REQ-038 Scenario: count=126 with PARTICLE_ID_WIDTH=7 -> terminal ids=127, no wrap, done asserted.
